// File: rtl/audio_dac_sequencer.sv
// Sample-rate scheduler, source mixer and soft-mute gain ramp feeding the stereo DAC.
// Optional auxiliary (CD/AHI) source mixing is built when AUX_MIX_EN is defined.
module audio_dac_sequencer #(
    parameter int TICK_DIV  = 640,
    parameter int GAIN_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        src0_valid,
    output logic        src0_ready,
    input  logic [15:0] src0_l,
    input  logic [15:0] src0_r,
`ifdef AUX_MIX_EN
    input  logic        src1_valid,
    output logic        src1_ready,
    input  logic [15:0] src1_l,
    input  logic [15:0] src1_r,
`endif
    output logic        tick,
    output logic [15:0] d_l,
    output logic [15:0] d_r,
    output logic [1:0]  state,
    output logic [7:0]  underrun_count
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW    = GAIN_BITS + 1;
    localparam int PW    = 16 + GAIN_BITS + 2;
    localparam logic [GW-1:0] UNITY    = GW'(1) << GAIN_BITS;
    localparam logic [GW-1:0] GAIN_ONE = GW'(1);

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [GW-1:0]       gain_q;
    logic [1:0]          stage_q;
    logic signed [15:0]  held0_l, held0_r;
    logic signed [15:0]  mix_l, mix_r;
    logic signed [PW-1:0] prod_l, prod_r;
    logic                underrun;

    // Handshake: a source is accepted when valid & ready at a clock edge; ready is
    // asserted only in the one-cycle tick, and a source must hold its data until then.
    assign tick       = (div_q == DIV_W'(TICK_DIV - 1));
    assign src0_ready = tick;
    assign state      = state_q;

`ifdef AUX_MIX_EN
    logic signed [15:0] held1_l, held1_r;

    assign src1_ready = tick;
    assign underrun   = !src0_valid || !src1_valid;

    function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        logic signed [16:0] s;
        s = {a[15], a} + {b[15], b};
        case (s[16:15])
            2'b01:   sat_add = 16'sh7FFF;
            2'b10:   sat_add = 16'sh8000;
            default: sat_add = s[15:0];
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held1_l <= '0;
            held1_r <= '0;
        end else if (tick && src1_valid) begin
            held1_l <= src1_l;
            held1_r <= src1_r;
        end
    end
`else
    assign underrun = !src0_valid;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // On underrun the held register simply keeps the previous sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held0_l <= '0;
            held0_r <= '0;
        end else if (tick && src0_valid) begin
            held0_l <= src0_l;
            held0_r <= src0_r;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_count <= '0;
        end else if (tick && underrun && state_q == RUN && underrun_count != 8'hFF) begin
            underrun_count <= underrun_count + 8'd1;
        end
    end

    // Gain ramp: one LSB per tick, reversible mid-ramp without any jump.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MUTED;
            gain_q  <= '0;
        end else if (tick) begin
            case (state_q)
                MUTED: begin
                    gain_q <= '0;
                    if (enable) state_q <= RAMP_UP;
                end
                RUN: begin
                    if (!enable) begin
                        gain_q  <= UNITY - GAIN_ONE;
                        state_q <= RAMP_DOWN;
                    end
                end
                default: begin
                    if (enable) begin
                        if (gain_q >= UNITY - GAIN_ONE) begin
                            gain_q  <= UNITY;
                            state_q <= RUN;
                        end else begin
                            gain_q  <= gain_q + GAIN_ONE;
                            state_q <= RAMP_UP;
                        end
                    end else begin
                        if (gain_q <= GAIN_ONE) begin
                            gain_q  <= '0;
                            state_q <= MUTED;
                        end else begin
                            gain_q  <= gain_q - GAIN_ONE;
                            state_q <= RAMP_DOWN;
                        end
                    end
                end
            endcase
        end
    end

    // stage_q[0] marks the cycle after the tick (held valid), stage_q[1] the one after that (mix valid).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[0], tick};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mix_l <= '0;
            mix_r <= '0;
        end else if (stage_q[0]) begin
`ifdef AUX_MIX_EN
            mix_l <= sat_add(held0_l, held1_l);
            mix_r <= sat_add(held0_r, held1_r);
`else
            mix_l <= held0_l;
            mix_r <= held0_r;
`endif
        end
    end

    assign prod_l = PW'(mix_l) * $signed(PW'(gain_q));
    assign prod_r = PW'(mix_r) * $signed(PW'(gain_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_l <= 16'h8000;
            d_r <= 16'h8000;
        end else if (stage_q[1]) begin
            d_l <= 16'(prod_l >>> GAIN_BITS) + 16'h8000;
            d_r <= 16'(prod_r >>> GAIN_BITS) + 16'h8000;
        end
    end

endmodule

// File: tb/tb_audio_dac_sequencer.sv
// Directed bench for audio_dac_sequencer: tick timing, gain ramp, underruns, mute ramp,
// async reset and mix saturation, using a short tick divider to keep the run small.
module tb_audio_dac_sequencer;

    localparam int TD = 16;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        src0_valid;
    logic        src0_ready;
    logic [15:0] src0_l, src0_r;
`ifdef AUX_MIX_EN
    logic        src1_valid;
    logic        src1_ready;
    logic [15:0] src1_l, src1_r;
`endif
    logic        tick;
    logic [15:0] d_l, d_r;
    logic [1:0]  state;
    logic [7:0]  underrun_count;

    int checks = 0;
    int errors = 0;
    int cnt;

    audio_dac_sequencer #(.TICK_DIV(TD), .GAIN_BITS(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .src0_valid     (src0_valid),
        .src0_ready     (src0_ready),
        .src0_l         (src0_l),
        .src0_r         (src0_r),
`ifdef AUX_MIX_EN
        .src1_valid     (src1_valid),
        .src1_ready     (src1_ready),
        .src1_l         (src1_l),
        .src1_r         (src1_r),
`endif
        .tick           (tick),
        .d_l            (d_l),
        .d_r            (d_r),
        .state          (state),
        .underrun_count (underrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge inside the next tick cycle.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 2 * TD);
        if (tick !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL tick_timeout observed=no_tick expected=tick_within_%0d", 2 * TD);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) wait_tick();
    endtask

    task automatic to_t3();
        repeat (3) @(negedge clk);
    endtask

    task automatic count_first_tick();
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (tick !== 1'b1 && cnt < 2 * TD);
        check("first_tick_delay", 32'(cnt), 32'(TD - 1));
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        src0_valid = 1'b0;
        src0_l = 16'h0000;
        src0_r = 16'h0000;
`ifdef AUX_MIX_EN
        src1_valid = 1'b1;
        src1_l = 16'h0000;
        src1_r = 16'h0000;
`endif
        repeat (3) @(negedge clk);
        check("rst_d_l", 32'(d_l), 32'h8000);
        check("rst_d_r", 32'(d_r), 32'h8000);
        check("rst_state", 32'(state), 32'd0);
        check("rst_underrun", 32'(underrun_count), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_ready", 32'(src0_ready), 32'd0);

        reset = 1'b0;
        count_first_tick();
        check("ready_at_tick", 32'(src0_ready), 32'd1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (tick !== 1'b1 && cnt < 2 * TD);
        check("tick_period", 32'(cnt), 32'(TD));
        @(negedge clk);
        check("ready_off_tick", 32'(src0_ready), 32'd0);

        // Muted idle
        ticks(3);
        to_t3();
        check("mute_d_l", 32'(d_l), 32'h8000);
        check("mute_d_r", 32'(d_r), 32'h8000);
        check("mute_state", 32'(state), 32'd0);

        // Ramp up to unity with a constant source
        src0_valid = 1'b1;
        src0_l = 16'h4000;
        src0_r = 16'hC000;
        enable = 1'b1;
        wait_tick();
        @(negedge clk);
        check("ramp_enter_state", 32'(state), 32'd1);
        for (int i = 1; i <= 256; i++) begin
            wait_tick();
            @(negedge clk);
            check("ramp_state", 32'(state), (i < 256) ? 32'd1 : 32'd2);
            @(negedge clk);
            check("ramp_d_hold_t2", 32'(d_l), 32'(32'h8000 + 64 * (i - 1)));
            @(negedge clk);
            check("ramp_d_l_t3", 32'(d_l), 32'(32'h8000 + 64 * i));
            check("ramp_d_r_t3", 32'(d_r), 32'(32'h8000 - 64 * i));
        end
        check("run_d_l_final", 32'(d_l), 32'hC000);
        check("run_d_r_final", 32'(d_r), 32'h4000);

        // Underruns in RUN hold the last sample and count, saturating
        src0_valid = 1'b0;
        src0_l = 16'h1234;
        src0_r = 16'h5678;
        ticks(5);
        to_t3();
        check("underrun_5", 32'(underrun_count), 32'd5);
        check("underrun_hold_l", 32'(d_l), 32'hC000);
        check("underrun_hold_r", 32'(d_r), 32'h4000);
        check("underrun_state", 32'(state), 32'd2);
        ticks(249);
        @(negedge clk);
        check("underrun_254", 32'(underrun_count), 32'd254);
        ticks(1);
        @(negedge clk);
        check("underrun_255", 32'(underrun_count), 32'd255);
        ticks(50);
        @(negedge clk);
        check("underrun_sat", 32'(underrun_count), 32'd255);

        // Asynchronous reset between clock edges
        src0_valid = 1'b1;
        src0_l = 16'h4000;
        src0_r = 16'hC000;
        wait_tick();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_d_l", 32'(d_l), 32'h8000);
        check("arst_d_r", 32'(d_r), 32'h8000);
        check("arst_state", 32'(state), 32'd0);
        check("arst_ready", 32'(src0_ready), 32'd0);
        check("arst_underrun", 32'(underrun_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        count_first_tick();

        // Ramp up to gain 100, then mute: gain reaches 0 after 100 ticks
        @(negedge clk);
        check("r100_enter_state", 32'(state), 32'd1);
        ticks(100);
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("gain100_d_l", 32'(d_l), 32'h9900);
        check("gain100_d_r", 32'(d_r), 32'h6700);
        wait_tick();
        @(negedge clk);
        check("rdown_state", 32'(state), 32'd3);
        repeat (2) @(negedge clk);
        check("gain99_d_l", 32'(d_l), 32'h98C0);
        ticks(98);
        @(negedge clk);
        check("gain1_state", 32'(state), 32'd3);
        wait_tick();
        @(negedge clk);
        check("muted_again_state", 32'(state), 32'd0);
        repeat (2) @(negedge clk);
        check("muted_again_d_l", 32'(d_l), 32'h8000);
        check("muted_again_d_r", 32'(d_r), 32'h8000);
        check("muted_again_underrun", 32'(underrun_count), 32'd0);

        // Full-scale extremes at unity
        enable = 1'b1;
        wait_tick();
        ticks(256);
        @(negedge clk);
        check("unity_state", 32'(state), 32'd2);
        src0_l = 16'h7FFF;
        src0_r = 16'h8000;
        wait_tick();
        to_t3();
        check("fs_pos_d_l", 32'(d_l), 32'hFFFF);
        check("fs_neg_d_r", 32'(d_r), 32'h0000);

`ifdef AUX_MIX_EN
        src0_l = 16'h7000;
        src1_l = 16'h7000;
        src0_r = 16'h9000;
        src1_r = 16'h9000;
        wait_tick();
        to_t3();
        check("aux_sat_pos", 32'(d_l), 32'hFFFF);
        check("aux_sat_neg", 32'(d_r), 32'h0000);
        // src1 underrun keeps the last src1 sample
        src1_valid = 1'b0;
        src1_l = 16'h0000;
        src1_r = 16'h0000;
        src0_l = 16'h0100;
        src0_r = 16'h0000;
        wait_tick();
        to_t3();
        check("aux_hold_l", 32'(d_l), 32'hF100);
        check("aux_hold_r", 32'(d_r), 32'h1000);
        check("aux_underrun", 32'(underrun_count), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
